ps2_ascii_queue: RTL and testbench
==================================

PS2_ASCII_QUEUE -- requirements
Module: ps2_ascii_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter CNT_W, default 4, width of fill count; SHALL equal log2(DEPTH)+1.
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 ps2_key_pressed  input  1  one-cycle strobe; ps2_key_data valid this cycle.
REQ-006 ps2_key_data  input  8  raw PS/2 set-2 scancode byte.
REQ-007 clear  input  1  synchronous flush of FIFO and overflow flag; decoder state kept.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 out_valid  output  1  FIFO non-empty; out_data holds head character.
REQ-010 out_data  output  8  ASCII character at FIFO head (first-word-fall-through).
REQ-011 fill_count  output  CNT_W  number of stored characters, 0..DEPTH.
REQ-012 overflow  output  1  sticky; set when a character is dropped because the FIFO is full.
REQ-013 caps_on  output  1  caps-lock state (see Configuration).

Function
REQ-014 Decoder FSM states: IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (0xE0 then 0xF0); advances only on ps2_key_pressed.
REQ-015 IDLE: 0xF0->BRK, 0xE0->EXT, any other byte = make code, stay IDLE.
REQ-016 BRK: next byte = break code, ->IDLE; EXT: 0xF0->EXT_BRK, else extended make ->IDLE; EXT_BRK: next byte ->IDLE.
REQ-017 Shift register bit: set on make 0x12 or 0x59, cleared on break 0x12 or 0x59; extended codes do not affect it.
REQ-018 Non-extended make map: letters A-Z (0x1C A .. 0x1A Z, standard set-2) -> 0x61..0x7A, or 0x41..0x5A when upper-case active; digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 -> 0x30..0x39; 0x29->0x20; 0x5A->0x0D; 0x66->0x08.
REQ-019 Upper-case active = shift XOR caps_on; digits unaffected by shift.
REQ-020 Break codes, extended codes, modifiers, unmapped makes SHALL never enqueue.
REQ-021 Latency: mapped make strobed in cycle N is written at edge ending N; out_valid=1 in N+1 if FIFO was empty.
REQ-022 Pop occurs when out_valid & out_ready; head advances at that edge.
REQ-023 Full (fill_count==DEPTH) with push and no pop: character dropped, overflow set, contents unchanged.
REQ-024 Full with push and pop same cycle: both performed, fill_count stays DEPTH, no overflow.
REQ-025 Empty: out_ready ignored, fill_count stays 0; push+pop on empty = push only.
REQ-026 Read/write pointers wrap modulo DEPTH; fill_count never exceeds DEPTH or underflows.
REQ-027 clear: fill_count->0, out_valid->0, overflow->0 next cycle; push in same cycle discarded.

Reset
REQ-028 resetn=0 at a rising edge: FSM->IDLE, shift=0, caps_on=0, pointers=0, fill_count=0, out_valid=0, out_data=0x00, overflow=0.
REQ-029 Reset mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix; next byte decoded from IDLE.

Configuration
REQ-030 Macro PS2Q_CAPS_LOCK_EN defined: non-extended make 0x58 toggles caps_on; caps held-down repeats each toggle.
REQ-031 Macro undefined: caps_on tied 0, 0x58 treated as unmapped make, no caps logic synthesised.

Verification
REQ-032 Reset, strobe 0x1C -> cycle later out_valid=1, out_data=0x61, fill_count=1.
REQ-033 Strobe 0x12, 0x1C, 0xF0, 0x12, 0x1C -> queue holds 0x41 then 0x61; 0xF0 0x1C etc. enqueue nothing.
REQ-034 DEPTH=8, out_ready=0, push 9 mapped makes -> fill_count=8, overflow=1, first 8 chars drain in order.
REQ-035 Full, push 0x29 with out_ready=1 same cycle -> fill_count=8, overflow=0, tail=0x20.
REQ-036 Strobe 0xE0, 0x75, 0xE0, 0xF0, 0x75, then 0x16 -> only 0x31 enqueued.
REQ-037 With PS2Q_CAPS_LOCK_EN: 0x58, 0x1C -> caps_on=1, out 0x41; 0x58, 0x12, 0x1C -> caps_on=0, out 0x41.

Source files
------------

// File: rtl/ps2_ascii_queue_if.sv
// ============================================================================
// Module  : ps2_ascii_queue_if
// Brief   : Scancode input, ASCII stream output and status bundle for the queue.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_ascii_queue_if #(
    parameter int CNT_W = 4
);
    logic             ps2_key_pressed;
    logic [7:0]       ps2_key_data;
    logic             clear;
    logic             out_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] fill_count;
    logic             overflow;
    logic             caps_on;

    modport master (
        output ps2_key_pressed, ps2_key_data, clear, out_ready,
        input  out_valid, out_data, fill_count, overflow, caps_on
    );

    modport slave (
        input  ps2_key_pressed, ps2_key_data, clear, out_ready,
        output out_valid, out_data, fill_count, overflow, caps_on
    );
endinterface

`default_nettype wire

// File: rtl/ps2_ascii_queue.sv
// ============================================================================
// Module  : ps2_ascii_queue
// Brief   : PS/2 set-2 scancode decoder feeding a first-word-fall-through ASCII
//           FIFO. Optional caps-lock support enabled by macro PS2Q_CAPS_LOCK_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_ascii_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    ps2_ascii_queue_if.slave  bus
);
    localparam int c_AW = $clog2(DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_BRK     = 2'd1;
    localparam logic [1:0] c_ST_EXT     = 2'd2;
    localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_shift;
    logic            w_caps;
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic            r_overflow;

    logic [7:0] w_byte;
    logic       w_make;
    logic       w_brk;
    logic       w_is_shift;
    logic [7:0] w_map_char;
    logic       w_is_letter;
    logic [7:0] w_char;
    logic       w_push_req;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_push;

    assign w_byte     = bus.ps2_key_data;
    assign w_make     = bus.ps2_key_pressed && (r_state == c_ST_IDLE) &&
                        (w_byte != 8'hF0) && (w_byte != 8'hE0);
    assign w_brk      = bus.ps2_key_pressed && (r_state == c_ST_BRK);
    assign w_is_shift = (w_byte == 8'h12) || (w_byte == 8'h59);

    always_comb begin
        w_state_nxt = r_state;
        if (bus.ps2_key_pressed) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_byte == 8'hF0)      w_state_nxt = c_ST_BRK;
                    else if (w_byte == 8'hE0) w_state_nxt = c_ST_EXT;
                end
                c_ST_EXT:  w_state_nxt = (w_byte == 8'hF0) ? c_ST_EXT_BRK : c_ST_IDLE;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
            r_shift <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_make && w_is_shift)
                r_shift <= 1'b1;
            else if (w_brk && w_is_shift)
                r_shift <= 1'b0;
        end
    end

`ifdef PS2Q_CAPS_LOCK_EN
    logic r_caps;

    // Typematic repeats of a held caps key each count as a fresh toggle.
    always_ff @(posedge clock) begin
        if (!resetn)
            r_caps <= 1'b0;
        else if (w_make && (w_byte == 8'h58))
            r_caps <= ~r_caps;
    end

    assign w_caps = r_caps;
`else
    assign w_caps = 1'b0;
`endif

    // Lower-case base map; zero marks an unmapped make code.
    always_comb begin
        case (w_byte)
            8'h1C: w_map_char = 8'h61;
            8'h32: w_map_char = 8'h62;
            8'h21: w_map_char = 8'h63;
            8'h23: w_map_char = 8'h64;
            8'h24: w_map_char = 8'h65;
            8'h2B: w_map_char = 8'h66;
            8'h34: w_map_char = 8'h67;
            8'h33: w_map_char = 8'h68;
            8'h43: w_map_char = 8'h69;
            8'h3B: w_map_char = 8'h6A;
            8'h42: w_map_char = 8'h6B;
            8'h4B: w_map_char = 8'h6C;
            8'h3A: w_map_char = 8'h6D;
            8'h31: w_map_char = 8'h6E;
            8'h44: w_map_char = 8'h6F;
            8'h4D: w_map_char = 8'h70;
            8'h15: w_map_char = 8'h71;
            8'h2D: w_map_char = 8'h72;
            8'h1B: w_map_char = 8'h73;
            8'h2C: w_map_char = 8'h74;
            8'h3C: w_map_char = 8'h75;
            8'h2A: w_map_char = 8'h76;
            8'h1D: w_map_char = 8'h77;
            8'h22: w_map_char = 8'h78;
            8'h35: w_map_char = 8'h79;
            8'h1A: w_map_char = 8'h7A;
            8'h45: w_map_char = 8'h30;
            8'h16: w_map_char = 8'h31;
            8'h1E: w_map_char = 8'h32;
            8'h26: w_map_char = 8'h33;
            8'h25: w_map_char = 8'h34;
            8'h2E: w_map_char = 8'h35;
            8'h36: w_map_char = 8'h36;
            8'h3D: w_map_char = 8'h37;
            8'h3E: w_map_char = 8'h38;
            8'h46: w_map_char = 8'h39;
            8'h29: w_map_char = 8'h20;
            8'h5A: w_map_char = 8'h0D;
            8'h66: w_map_char = 8'h08;
            default: w_map_char = 8'h00;
        endcase
    end

    assign w_is_letter = (w_map_char >= 8'h61) && (w_map_char <= 8'h7A);
    assign w_char      = (w_is_letter && (r_shift ^ w_caps)) ? (w_map_char - 8'h20) : w_map_char;
    assign w_push_req  = w_make && (w_map_char != 8'h00);

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && bus.out_ready;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_push  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (w_push && !bus.clear)
            r_mem[r_wr_ptr] <= w_char;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            if (w_push_req && !w_push)
                r_overflow <= 1'b1;
        end
    end

    assign bus.out_valid  = !w_empty;
    assign bus.out_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.fill_count = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.caps_on    = w_caps;
endmodule

`default_nettype wire

// File: tb/tb_ps2_ascii_queue.sv
// ============================================================================
// Module  : tb_ps2_ascii_queue
// Brief   : Self-checking bench for ps2_ascii_queue against a queue-based model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_ascii_queue;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    ps2_ascii_queue_if #(.CNT_W(CNT_W)) bus ();

    ps2_ascii_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: character queue plus decoder flags.
    logic [7:0] m_q [$];
    bit m_shift, m_caps, m_ovf, m_f0, m_e0;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                     8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h1A, 8'h2B, 8'h45, 8'h16, 8'h46, 8'h29,
                              8'h5A, 8'h66, 8'h12, 8'h59, 8'hF0, 8'hF0, 8'hE0, 8'h75,
                              8'h58, 8'h76, 8'h00, 8'h3C};

    function automatic logic [7:0] ref_char(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == b)
                r = ((m_shift ^ m_caps) ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == b)
                r = 8'h30 + 8'(i);
        if (b == 8'h29) r = 8'h20;
        if (b == 8'h5A) r = 8'h0D;
        if (b == 8'h66) r = 8'h08;
        return r;
    endfunction

    // Drives one clock cycle and advances the model; returns #1 after the edge.
    task automatic drive_cycle(input bit p, input logic [7:0] d, input bit rdy, input bit clr);
        bit pop;
        logic [7:0] ch;
        @(negedge clock);
        bus.ps2_key_pressed = p;
        bus.ps2_key_data    = d;
        bus.out_ready       = rdy;
        bus.clear           = clr;
        pop = (m_q.size() != 0) && rdy;
        ch  = 8'h00;
        if (p) begin
            if (m_f0 && !m_e0) begin
                if (d == 8'h12 || d == 8'h59) m_shift = 0;
                m_f0 = 0;
            end else if (m_e0) begin
                if (!m_f0 && d == 8'hF0) m_f0 = 1;
                else begin m_e0 = 0; m_f0 = 0; end
            end else if (d == 8'hF0) begin
                m_f0 = 1;
            end else if (d == 8'hE0) begin
                m_e0 = 1;
            end else begin
                ch = ref_char(d);
                if (d == 8'h12 || d == 8'h59) m_shift = 1;
`ifdef PS2Q_CAPS_LOCK_EN
                if (d == 8'h58) m_caps = ~m_caps;
`endif
            end
        end
        if (clr) begin
            m_q.delete();
            m_ovf = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (ch != 8'h00) begin
                if (m_q.size() < DEPTH) m_q.push_back(ch);
                else m_ovf = 1;
            end
        end
        @(posedge clock);
        #1;
        bus.ps2_key_pressed = 1'b0;
        bus.clear           = 1'b0;
        bus.out_ready       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        bus.ps2_key_pressed = 1'b0;
        bus.clear = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        m_q.delete();
        m_shift = 0; m_caps = 0; m_ovf = 0; m_f0 = 0; m_e0 = 0;
    endtask

    task automatic test_reset();
        drive_cycle(1, 8'h1C, 0, 0);
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.out_data); end
        checks++; if (bus.fill_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.fill_count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.overflow); end
        checks++; if (bus.caps_on !== 1'b0) begin errors++; $display("FAIL reset_caps got %b exp 0", bus.caps_on); end
    endtask

    task automatic test_single_make();
        drive_cycle(1, 8'h1C, 0, 0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h61) begin errors++; $display("FAIL single_data got %h exp 61", bus.out_data); end
        checks++; if (bus.fill_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", bus.fill_count); end
        drive_cycle(0, 8'h00, 1, 0);
        drive_cycle(0, 8'h00, 1, 0);
        checks++; if (bus.fill_count !== 4'd0) begin errors++; $display("FAIL empty_pop_count got %0d exp 0", bus.fill_count); end
    endtask

    task automatic test_shift();
        logic [7:0] seq [7] = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C, 8'hF0, 8'h1C};
        for (int i = 0; i < 7; i++) drive_cycle(1, seq[i], 0, 0);
        checks++; if (bus.fill_count !== 4'd2) begin errors++; $display("FAIL shift_count got %0d exp 2", bus.fill_count); end
        checks++; if (bus.out_data !== 8'h41) begin errors++; $display("FAIL shift_upper got %h exp 41", bus.out_data); end
        drive_cycle(0, 8'h00, 1, 0);
        checks++; if (bus.out_data !== 8'h61) begin errors++; $display("FAIL shift_lower got %h exp 61", bus.out_data); end
        drive_cycle(0, 8'h00, 1, 0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL shift_drained got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i < 10; i++) drive_cycle(1, digit_codes[i], 0, 0);
        checks++; if (bus.fill_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", bus.fill_count); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.out_data !== 8'h31 + 8'(i)) begin
                errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, bus.out_data, 8'h31 + 8'(i));
            end
            drive_cycle(0, 8'h00, 1, 0);
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", bus.out_valid); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
        drive_cycle(0, 8'h00, 0, 1);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) drive_cycle(1, letter_codes[i], 0, 0);
        checks++; if (bus.fill_count !== 4'd8) begin errors++; $display("FAIL fpp_full got %0d exp 8", bus.fill_count); end
        drive_cycle(1, 8'h29, 1, 0);
        checks++; if (bus.fill_count !== 4'd8) begin errors++; $display("FAIL fpp_count got %0d exp 8", bus.fill_count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", bus.overflow); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus.out_data !== 8'h62 + 8'(i)) begin
                errors++; $display("FAIL fpp_drain%0d got %h exp %h", i, bus.out_data, 8'h62 + 8'(i));
            end
            drive_cycle(0, 8'h00, 1, 0);
        end
        checks++; if (bus.out_data !== 8'h20) begin errors++; $display("FAIL fpp_tail got %h exp 20", bus.out_data); end
        drive_cycle(0, 8'h00, 1, 0);
    endtask

    task automatic test_extended();
        logic [7:0] seq [6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h16};
        for (int i = 0; i < 6; i++) drive_cycle(1, seq[i], 0, 0);
        checks++; if (bus.fill_count !== 4'd1) begin errors++; $display("FAIL ext_count got %0d exp 1", bus.fill_count); end
        checks++; if (bus.out_data !== 8'h31) begin errors++; $display("FAIL ext_data got %h exp 31", bus.out_data); end
        drive_cycle(0, 8'h00, 1, 0);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) drive_cycle(1, letter_codes[i], 0, 0);
        drive_cycle(1, 8'h1C, 1, 1);
        checks++; if (bus.fill_count !== 4'd0) begin errors++; $display("FAIL clear_count got %0d exp 0", bus.fill_count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %b exp 0", bus.out_valid); end
        drive_cycle(1, 8'h32, 0, 0);
        checks++; if (bus.out_data !== 8'h62) begin errors++; $display("FAIL clear_after got %h exp 62", bus.out_data); end
        drive_cycle(0, 8'h00, 1, 0);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, 8'h12, 0, 0);
        drive_cycle(1, 8'hF0, 0, 0);
        do_reset();
        drive_cycle(1, 8'h1C, 0, 0);
        checks++; if (bus.fill_count !== 4'd1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", bus.fill_count); end
        checks++; if (bus.out_data !== 8'h61) begin errors++; $display("FAIL rstmid_data got %h exp 61", bus.out_data); end
        drive_cycle(0, 8'h00, 1, 0);
    endtask

    task automatic test_caps();
`ifdef PS2Q_CAPS_LOCK_EN
        drive_cycle(1, 8'h58, 0, 0);
        drive_cycle(1, 8'h1C, 0, 0);
        checks++; if (bus.caps_on !== 1'b1) begin errors++; $display("FAIL caps_on got %b exp 1", bus.caps_on); end
        checks++; if (bus.out_data !== 8'h41) begin errors++; $display("FAIL caps_upper got %h exp 41", bus.out_data); end
        drive_cycle(0, 8'h00, 1, 0);
        drive_cycle(1, 8'h58, 0, 0);
        drive_cycle(1, 8'h12, 0, 0);
        drive_cycle(1, 8'h1C, 0, 0);
        checks++; if (bus.caps_on !== 1'b0) begin errors++; $display("FAIL caps_off got %b exp 0", bus.caps_on); end
        checks++; if (bus.out_data !== 8'h41) begin errors++; $display("FAIL caps_shift got %h exp 41", bus.out_data); end
        drive_cycle(0, 8'h00, 1, 0);
        drive_cycle(1, 8'hF0, 0, 0);
        drive_cycle(1, 8'h12, 0, 0);
`else
        drive_cycle(1, 8'h58, 0, 0);
        checks++; if (bus.fill_count !== 4'd0) begin errors++; $display("FAIL nocaps_count got %0d exp 0", bus.fill_count); end
        drive_cycle(1, 8'h1C, 0, 0);
        checks++; if (bus.caps_on !== 1'b0) begin errors++; $display("FAIL nocaps_on got %b exp 0", bus.caps_on); end
        checks++; if (bus.out_data !== 8'h61) begin errors++; $display("FAIL nocaps_data got %h exp 61", bus.out_data); end
        drive_cycle(0, 8'h00, 1, 0);
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive_cycle(($urandom % 3) != 0, pool[$urandom % 20], ($urandom % 10) < 3,
                        ($urandom % 50) == 0);
            checks++;
            if (bus.fill_count !== CNT_W'(m_q.size())) begin
                errors++; $display("FAIL rnd_count@%0d got %0d exp %0d", n, bus.fill_count, m_q.size());
            end
            checks++;
            if (bus.out_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid@%0d got %b exp %b", n, bus.out_valid, m_q.size() != 0);
            end
            checks++;
            if (bus.overflow !== m_ovf) begin
                errors++; $display("FAIL rnd_ovf@%0d got %b exp %b", n, bus.overflow, m_ovf);
            end
            checks++;
            if (bus.caps_on !== m_caps) begin
                errors++; $display("FAIL rnd_caps@%0d got %b exp %b", n, bus.caps_on, m_caps);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (bus.out_data !== m_q[0]) begin
                    errors++; $display("FAIL rnd_data@%0d got %h exp %h", n, bus.out_data, m_q[0]);
                end
            end
        end
    endtask

    initial begin
        bus.ps2_key_pressed = 1'b0;
        bus.ps2_key_data    = 8'h00;
        bus.clear           = 1'b0;
        bus.out_ready       = 1'b0;
        do_reset();
        test_reset();
        test_single_make();
        test_shift();
        test_overflow();
        test_full_push_pop();
        test_extended();
        test_clear();
        test_reset_mid();
        test_caps();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
